// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch sequencer. Fetches the word at the current
//                PC over a req/ack handshake and pre-decodes JMP, RET and HLT.
//                It drives the PC advance/jump/return strobes and hands every
//                other instruction to the execute stage over valid/ready.
//                Optional perf counters are enabled with `define FETCH_PERF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [3:0] OP_JMP = 4'hC,
  parameter logic [3:0] OP_RET = 4'hD,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_address,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        ins_count,
  output logic        jump_enable,
  output logic [15:0] jump_address,
  output logic        return_enable,
  output logic        halted,
  input  logic        resume
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_DECODE  = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_addr;
  logic        r_addr_cap;

  // The PC loads on the same edge that enters REQ, so during the first REQ
  // cycle the live pc_address is presented while it is being captured; every
  // later cycle of the request presents the captured copy.
  assign mem_addr = (r_state == ST_REQ && !r_addr_cap) ? pc_address : r_addr;
  assign instr    = r_ir;

  // Sequencer state machine with registered strobes and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ir          <= 16'h0000;
      r_addr        <= 16'h0000;
      r_addr_cap    <= 1'b0;
      mem_req       <= 1'b0;
      instr_valid   <= 1'b0;
      ins_count     <= 1'b0;
      jump_enable   <= 1'b0;
      return_enable <= 1'b0;
      jump_address  <= 16'h0000;
      halted        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          mem_req    <= 1'b1;
          r_addr_cap <= 1'b0;
          r_state    <= ST_REQ;
        end

        ST_REQ: begin
          if (!r_addr_cap) begin
            r_addr     <= pc_address;
            r_addr_cap <= 1'b1;
          end
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            mem_req <= 1'b0;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (r_ir[15:12] == OP_JMP) begin
            jump_address <= {4'b0000, r_ir[11:0]};
            ins_count    <= 1'b1;
            jump_enable  <= 1'b1;
            r_state      <= ST_ADVANCE;
          end else if (r_ir[15:12] == OP_RET) begin
            ins_count     <= 1'b1;
            return_enable <= 1'b1;
            r_state       <= ST_ADVANCE;
          end else if (r_ir[15:12] == OP_HLT) begin
            halted  <= 1'b1;
            r_state <= ST_HALT;
          end else begin
            instr_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            ins_count   <= 1'b1;
            r_state     <= ST_ADVANCE;
          end
        end

        ST_ADVANCE: begin
          ins_count     <= 1'b0;
          jump_enable   <= 1'b0;
          return_enable <= 1'b0;
          mem_req       <= 1'b1;
          r_addr_cap    <= 1'b0;
          r_state       <= ST_REQ;
        end

        ST_HALT: begin
          if (resume) begin
            halted    <= 1'b0;
            ins_count <= 1'b1;
            r_state   <= ST_ADVANCE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Count completed instructions and cycles spent waiting on memory or execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (r_state == ST_ADVANCE) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if ((r_state == ST_REQ && !mem_ack) || (r_state == ST_ISSUE && !instr_ready)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer with a
//                small instruction memory and PC model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [15:0] C_RET_ADDR = 16'h0300;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_address;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ins_count;
  logic        jump_enable;
  logic [15:0] jump_address;
  logic        return_enable;
  logic        halted;
  logic        resume;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
  logic [15:0] fetch_snap;
  logic [15:0] stall_snap;
`endif

  int checks   = 0;
  int failures = 0;

  // memory / execute model state
  int ack_delay   = 0;
  int ready_delay = 0;
  int req_cycles  = 0;
  int issue_cycles = 0;
  logic [15:0] held_instr;
  int n_ins, n_valid, n_req, n_both, stable_err;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_address    (pc_address),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .ins_count     (ins_count),
    .jump_enable   (jump_enable),
    .jump_address  (jump_address),
    .return_enable (return_enable),
    .halted        (halted),
    .resume        (resume)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0001: return 16'hC0A5;
      16'h00A5: return 16'hD000;
      16'h0300: return 16'hF000;
      16'h0301: return 16'h5A5A;
      16'h0040: return 16'h7777;
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic clear_counts();
    n_ins = 0; n_valid = 0; n_req = 0; stable_err = 0;
  endtask

  // One clock cycle, entered and left at a falling edge: respond as memory and
  // execute stage, observe strobes, and update the PC just after the rising edge.
  task automatic cycle();
    logic        adv, jmp, ret;
    logic [15:0] ja;
    if (mem_req) begin
      n_req++;
      mem_ack   = (req_cycles == ack_delay);
      mem_rdata = mem_word(mem_addr);
      if (mem_ack) req_cycles = 0;
      else         req_cycles++;
    end else begin
      mem_ack    = 1'b0;
      req_cycles = 0;
    end
    if (instr_valid) begin
      n_valid++;
      if (issue_cycles > 0 && instr !== held_instr) stable_err++;
      held_instr  = instr;
      instr_ready = (issue_cycles == ready_delay);
      if (instr_ready) issue_cycles = 0;
      else             issue_cycles++;
    end else begin
      instr_ready  = 1'b0;
      issue_cycles = 0;
    end
    adv = ins_count; jmp = jump_enable; ret = return_enable; ja = jump_address;
    if (ins_count) n_ins++;
    if (jump_enable && return_enable) n_both++;
    @(posedge clk);
    #1;
    if (adv) pc_address = jmp ? ja : (ret ? C_RET_ADDR : pc_address + 16'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_address = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;
    instr_ready = 1'b0; resume = 1'b0; held_instr = 16'h0000; n_both = 0;
    clear_counts();
    repeat (2) @(negedge clk);

    // reset values
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_strobes", {ins_count, jump_enable, return_enable, halted}, 4'b0000);
    check("rst_jump_addr", jump_address, 16'h0000);

    // sequential instruction 16'h1234 at PC 0
    reset = 1'b0;
    cycle();                                   // IDLE
    check("seq_req", mem_req, 1'b1);
    check("seq_addr", mem_addr, 16'h0000);
    cycle();                                   // REQ, ack same cycle
    check("seq_dec_valid", instr_valid, 1'b0);
    cycle();                                   // DECODE
    check("seq_iss_valid", instr_valid, 1'b1);
    check("seq_iss_instr", instr, 16'h1234);
    cycle();                                   // ISSUE, ready high
    check("seq_adv_ins", ins_count, 1'b1);
    check("seq_adv_jr", {jump_enable, return_enable}, 2'b00);
    check("seq_adv_valid", instr_valid, 1'b0);
    cycle();                                   // ADVANCE
    check("seq_next_addr", mem_addr, 16'h0001);

    // JMP 16'hC0A5
    clear_counts();
    cycle(); cycle();                          // REQ, DECODE
    check("jmp_adv_ins", ins_count, 1'b1);
    check("jmp_adv_jr", {jump_enable, return_enable}, 2'b10);
    check("jmp_target", jump_address, 16'h00A5);
    cycle();                                   // ADVANCE
    check("jmp_fetch_req", mem_req, 1'b1);
    check("jmp_fetch_addr", mem_addr, 16'h00A5);

    // RET 16'hD000
    cycle(); cycle();
    check("ret_adv_ins", ins_count, 1'b1);
    check("ret_adv_jr", {jump_enable, return_enable}, 2'b01);
    cycle();
    check("ret_fetch_addr", mem_addr, C_RET_ADDR);

    // HLT 16'hF000
    cycle(); cycle();
    check("hlt_halted", halted, 1'b1);
    check("ctl_no_valid", n_valid, 0);
    clear_counts();
    repeat (20) cycle();
    check("hlt_no_req", n_req, 0);
    check("hlt_no_ins", n_ins, 0);
    check("hlt_still", halted, 1'b1);
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    check("res_ins", ins_count, 1'b1);
    check("res_halted", halted, 1'b0);
    check("res_jr", {jump_enable, return_enable}, 2'b00);
    cycle();
    check("res_fetch_addr", mem_addr, 16'h0301);
    check("res_fetch_req", mem_req, 1'b1);

    // stalls: ack 3 cycles late, ready low 5 cycles, resume held (ignored)
    ack_delay = 3; ready_delay = 5;
    clear_counts();
`ifdef FETCH_PERF_EN
    fetch_snap = fetch_count; stall_snap = stall_count;
`endif
    resume = 1'b1;
    repeat (12) cycle();
    resume = 1'b0;
    check("stl_ins", n_ins, 1);
    check("stl_valid_cycles", n_valid, 6);
    check("stl_instr_stable", stable_err, 0);
    check("stl_held_instr", held_instr, 16'h5A5A);
    check("stl_next_addr", mem_addr, 16'h0302);
    check("stl_next_req", mem_req, 1'b1);
`ifdef FETCH_PERF_EN
    check("perf_fetch", fetch_count - fetch_snap, 16'd1);
    check("perf_stall", stall_count - stall_snap, 16'd8);
`endif
    ack_delay = 0; ready_delay = 0;

    // reset during REQ
    reset = 1'b1;
    #1;
    check("rreq_mem_req", mem_req, 1'b0);
    check("rreq_mem_addr", mem_addr, 16'h0000);
    @(negedge clk);
    pc_address = 16'h0040;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hC0FF;      // stray ack while IDLE
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rrel_req", mem_req, 1'b1);
    check("rrel_addr", mem_addr, 16'h0040);
    req_cycles = 0;
    cycle(); cycle();                          // REQ, DECODE
    check("stray_valid", instr_valid, 1'b1);
    check("stray_instr", instr, 16'h7777);

    // reset during ISSUE
    instr_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("riss_valid", instr_valid, 1'b0);
    check("riss_instr", instr, 16'h0000);
    @(negedge clk);
    pc_address = 16'h0123;
    reset = 1'b0;
    cycle();                                   // IDLE
    check("riss_fetch_addr", mem_addr, 16'h0123);
    check("riss_fetch_req", mem_req, 1'b1);
    check("strobe_excl", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
